// File: rtl/spi_eeprom_reader.sv
// SPI mode-0 EEPROM burst reader: READ (0x03) with address, optional RDSR (0x05).
// Define SPI_EEPROM_RDSR_EN to honour mode=1 as RDSR; otherwise every request is a READ.
module spi_eeprom_reader #(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned LEN_W    = 8,
   parameter int unsigned CLK_DIV  = 2,
   parameter int unsigned CS_SETUP = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] addr,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   output logic [7:0]        data_out,
   output logic              data_valid,
   input  logic              data_ready,
   output logic              done,
   output logic              flash_si,
   input  logic              flash_so,
   output logic              flash_sck,
   output logic              flash_cs_n,
   output logic              flash_wp_n,
   output logic              flash_hold_n
);

   localparam int unsigned TX_W      = ADDR_W + 8;
   localparam int unsigned BIT_W     = $clog2(TX_W + 1);
   localparam int unsigned FIRST_LOW = (CS_SETUP > CLK_DIV) ? CS_SETUP : CLK_DIV;
   localparam int unsigned DIV_W     = (FIRST_LOW < 2) ? 1 : $clog2(FIRST_LOW);
   localparam logic [7:0]  CMD_READ  = 8'h03;
   localparam logic [7:0]  CMD_RDSR  = 8'h05;

   typedef enum logic [2:0] {
      S_IDLE, S_CSS, S_CMD, S_ADDR, S_DATA, S_CSH, S_FIN
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [DIV_W-1:0]   r_div, w_div_nxt;
   logic [BIT_W-1:0]   r_bit, w_bit_nxt;
   logic [LEN_W-1:0]   r_left, w_left_nxt;
   logic [TX_W-1:0]    r_tx, w_tx_nxt;
   logic [7:0]         r_rx, w_rx_nxt;
   logic [7:0]         r_dout, w_dout_nxt;
   logic               r_rdsr, w_rdsr_nxt;
   logic               r_load, w_load_nxt;
   logic               r_sck, w_sck_nxt;
   logic               r_cs_n, w_cs_n_nxt;
   logic               r_busy, w_busy_nxt;
   logic               r_done, w_done_nxt;
   logic               r_valid, w_valid_nxt;
   logic               w_start_rdsr;
   logic               w_half_end;
   logic               w_field_last;
   logic               w_stall;

`ifdef SPI_EEPROM_RDSR_EN
   assign w_start_rdsr = mode;
`else
   logic w_unused_mode;
   assign w_start_rdsr  = 1'b0;
   assign w_unused_mode = mode;
`endif

   assign w_half_end   = (r_div == DIV_W'(CLK_DIV - 1));
   assign w_field_last = (r_state == S_ADDR) ? (r_bit == BIT_W'(ADDR_W - 1))
                                             : (r_bit == BIT_W'(7));
   // Hold SCK low before a byte's first rise while the previous byte is unaccepted
   assign w_stall      = (r_state == S_DATA) && (r_bit == '0) && r_valid && !data_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_div   <= '0;
         r_bit   <= '0;
         r_left  <= '0;
         r_tx    <= '0;
         r_rx    <= '0;
         r_dout  <= '0;
         r_rdsr  <= 1'b0;
         r_load  <= 1'b0;
         r_sck   <= 1'b0;
         r_cs_n  <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_div   <= w_div_nxt;
         r_bit   <= w_bit_nxt;
         r_left  <= w_left_nxt;
         r_tx    <= w_tx_nxt;
         r_rx    <= w_rx_nxt;
         r_dout  <= w_dout_nxt;
         r_rdsr  <= w_rdsr_nxt;
         r_load  <= w_load_nxt;
         r_sck   <= w_sck_nxt;
         r_cs_n  <= w_cs_n_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_valid <= w_valid_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_div_nxt   = r_div;
      w_bit_nxt   = r_bit;
      w_left_nxt  = r_left;
      w_tx_nxt    = r_tx;
      w_rx_nxt    = r_rx;
      w_dout_nxt  = r_dout;
      w_rdsr_nxt  = r_rdsr;
      w_load_nxt  = 1'b0;
      w_sck_nxt   = r_sck;
      w_cs_n_nxt  = r_cs_n;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      w_valid_nxt = r_valid;

      if (r_valid && data_ready) w_valid_nxt = 1'b0;
      if (r_load) begin
         w_dout_nxt  = r_rx;
         w_valid_nxt = 1'b1;
      end

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_CSS;
               w_busy_nxt  = 1'b1;
               w_cs_n_nxt  = 1'b0;
               w_div_nxt   = '0;
               w_bit_nxt   = '0;
               w_rdsr_nxt  = w_start_rdsr;
               w_left_nxt  = w_start_rdsr ? '0 : len;
               w_tx_nxt    = w_start_rdsr ? {CMD_RDSR, ADDR_W'(0)} : {CMD_READ, addr};
            end
         end
         // First low phase covers both chip-select setup and SI setup for the command MSB
         S_CSS: begin
            if (r_div == DIV_W'(FIRST_LOW - 1)) begin
               w_state_nxt = S_CMD;
               w_sck_nxt   = 1'b1;
               w_div_nxt   = '0;
            end else begin
               w_div_nxt = r_div + 1'b1;
            end
         end
         S_CMD, S_ADDR, S_DATA: begin
            if (!r_sck) begin
               if (!w_half_end) begin
                  w_div_nxt = r_div + 1'b1;
               end else if (!w_stall) begin
                  w_sck_nxt = 1'b1;
                  w_div_nxt = '0;
                  if (r_state == S_DATA) begin
                     w_rx_nxt   = {r_rx[6:0], flash_so};
                     w_load_nxt = (r_bit == BIT_W'(7));
                  end
               end
            end else if (!w_half_end) begin
               w_div_nxt = r_div + 1'b1;
            end else begin
               w_sck_nxt = 1'b0;
               w_div_nxt = '0;
               w_tx_nxt  = r_tx << 1;
               w_bit_nxt = r_bit + 1'b1;
               if (w_field_last) begin
                  w_bit_nxt = '0;
                  case (r_state)
                     S_CMD:   w_state_nxt = r_rdsr ? S_DATA : S_ADDR;
                     S_ADDR:  w_state_nxt = S_DATA;
                     default: begin
                        if (r_left == '0) w_state_nxt = S_CSH;
                        else              w_left_nxt  = r_left - 1'b1;
                     end
                  endcase
               end
            end
         end
         // Hold time counts only once the final byte has been taken
         S_CSH: begin
            if (!r_valid && !r_load) begin
               if (r_div == DIV_W'(CS_SETUP - 1)) begin
                  w_state_nxt = S_FIN;
                  w_cs_n_nxt  = 1'b1;
                  w_div_nxt   = '0;
               end else begin
                  w_div_nxt = r_div + 1'b1;
               end
            end
         end
         S_FIN: begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign busy         = r_busy;
   assign data_out     = r_dout;
   assign data_valid   = r_valid;
   assign done         = r_done;
   assign flash_si     = r_tx[TX_W-1];
   assign flash_sck    = r_sck;
   assign flash_cs_n   = r_cs_n;
   assign flash_wp_n   = 1'b1;
   assign flash_hold_n = 1'b1;

endmodule

// File: tb/tb_spi_eeprom_reader.sv
// Scoreboard bench for spi_eeprom_reader with a behavioural 25AA512-style EEPROM model.
module tb_spi_eeprom_reader;
   parameter int unsigned CLK_DIV  = 2;
   localparam int unsigned CS_SETUP = 2;

`ifdef SPI_EEPROM_RDSR_EN
   localparam bit RDSR_ON = 1'b1;
`else
   localparam bit RDSR_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        mode = 1'b0;
   logic [15:0] addr = '0;
   logic [7:0]  len = '0;
   logic        busy, data_valid, done;
   logic [7:0]  data_out;
   logic        data_ready = 1'b1;
   logic        flash_si, flash_so, flash_sck, flash_cs_n, flash_wp_n, flash_hold_n;

   spi_eeprom_reader #(.ADDR_W(16), .LEN_W(8), .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP)) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .addr(addr), .len(len),
      .busy(busy), .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
      .done(done), .flash_si(flash_si), .flash_so(flash_so), .flash_sck(flash_sck),
      .flash_cs_n(flash_cs_n), .flash_wp_n(flash_wp_n), .flash_hold_n(flash_hold_n));

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int n_done = 0;
   int n_acc = 0;
   int ready_mode = 0;
   logic [7:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // EEPROM model: mode 0, shifts SI on SCK rise, presents SO after SCK fall
   logic [7:0]  mem [0:65535];
   logic [7:0]  status_reg = 8'h02;
   logic [7:0]  m_cmd;
   logic [15:0] m_addr;
   logic [7:0]  m_byte;
   int          m_bits;
   int          m_k;
   logic        so_r = 1'b0;
   assign flash_so = so_r;

   always @(negedge flash_cs_n) begin
      m_bits = 0;
      m_cmd  = '0;
      m_addr = '0;
      so_r   = 1'b0;
   end
   always @(posedge flash_sck) if (!flash_cs_n) begin
      if (m_bits < 8) m_cmd = {m_cmd[6:0], flash_si};
      else if (m_cmd == 8'h03 && m_bits < 24) m_addr = {m_addr[14:0], flash_si};
      m_bits++;
   end
   always @(negedge flash_sck) if (!flash_cs_n) begin
      if (m_cmd == 8'h03 && m_bits >= 24) begin
         m_k    = m_bits - 24;
         m_byte = mem[16'(m_addr + 16'(m_k / 8))];
         so_r   = m_byte[7 - (m_k % 8)];
      end else if (m_cmd == 8'h05 && m_bits >= 8) begin
         so_r = status_reg[7 - ((m_bits - 8) % 8)];
      end else begin
         so_r = 1'b0;
      end
   end

   // Consumer-ready driver
   initial forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
         0:       data_ready = 1'b1;
         1:       data_ready = 1'($urandom_range(0, 1));
         default: data_ready = 1'b0;
      endcase
   end

   // Monitor: scoreboard pops, SCK phase timing, SI stability, done protocol
   logic p_sck = 1'b0, p_si = 1'b0, p_cs = 1'b1, p_done = 1'b0, p_rst = 1'b1;
   logic tracking = 1'b0, si_moved = 1'b0;
   int   hi_len = 0, lo_len = 0;
   logic [7:0] e_byte;

   always @(negedge clk) begin
      if (!reset && data_valid && data_ready) begin
         n_acc++;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_byte: got 0x%02h, expected no byte", data_out);
         end else begin
            e_byte = exp_q.pop_front();
            chk("byte", 32'(data_out), 32'(e_byte));
         end
      end
      if (reset || p_rst || flash_cs_n) begin
         tracking = 1'b0;
         hi_len   = 0;
         lo_len   = 0;
      end else if (flash_sck && !p_sck) begin
         if (tracking) chk("sck_low_min", 32'(lo_len >= int'(CLK_DIV)), 32'd1);
         hi_len   = 1;
         si_moved = (flash_si != p_si);
      end else if (flash_sck) begin
         hi_len++;
         if (flash_si != p_si) si_moved = 1'b1;
      end else if (p_sck) begin
         chk("sck_high_len", 32'(hi_len), 32'(CLK_DIV));
         chk("si_stable_high", 32'(si_moved), 32'd0);
         lo_len   = 1;
         tracking = 1'b1;
      end else begin
         lo_len++;
      end
      if (done) begin
         n_done++;
         chk("done_busy_low", 32'(busy), 32'd0);
         chk("cs_high_before_done", 32'(p_cs), 32'd1);
         chk("done_single_cycle", 32'(p_done), 32'd0);
      end
      p_sck  = flash_sck;
      p_si   = flash_si;
      p_cs   = flash_cs_n;
      p_done = done;
      p_rst  = reset;
   end

   task automatic issue(input logic m, input logic [15:0] a, input logic [7:0] l);
      if (RDSR_ON && m) exp_q.push_back(status_reg);
      else for (int i = 0; i <= int'(l); i++) exp_q.push_back(mem[16'(a + 16'(i))]);
      @(posedge clk);
      #1;
      start = 1'b1;
      mode  = m;
      addr  = a;
      len   = l;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
      chk("cs_low_after_start", 32'(flash_cs_n), 32'd0);
   endtask

   task automatic wait_done(input int budget);
      int d0;
      int k;
      d0 = n_done;
      k  = 0;
      while (n_done == d0 && k < budget) begin
         @(negedge clk);
         #1;
         k++;
      end
      chk("done_seen", 32'(n_done - d0), 32'd1);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      repeat (8) @(posedge clk);
      #1;
      chk("one_done_only", 32'(n_done - d0), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc0;
      int k;
      int bad;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      mem[0] = 8'hDE;
      mem[1] = 8'hAD;
      mem[2] = 8'hBE;
      mem[3] = 8'hEF;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cs_n", 32'(flash_cs_n), 32'd1);
      chk("rst_sck", 32'(flash_sck), 32'd0);
      chk("rst_si", 32'(flash_si), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(data_valid), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_dout", 32'(data_out), 32'd0);
      chk("wp_n", 32'(flash_wp_n), 32'd1);
      chk("hold_n", 32'(flash_hold_n), 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Basic burst DE AD BE EF
      ready_mode = 0;
      issue(1'b0, 16'h0000, 8'd3);
      wait_done(3000);

      // Backpressure: first byte held for 20 cycles
      ready_mode = 2;
      issue(1'b0, 16'h0000, 8'd3);
      k = 0;
      while (!data_valid && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk("first_valid_seen", 32'(data_valid), 32'd1);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk("stall_dout", 32'(data_out), 32'hDE);
         chk("stall_cs", 32'(flash_cs_n), 32'd0);
         chk("stall_valid", 32'(data_valid), 32'd1);
         if (c >= int'(CLK_DIV)) chk("stall_sck", 32'(flash_sck), 32'd0);
      end
      ready_mode = 0;
      wait_done(3000);

      // mode=1: RDSR when enabled, otherwise a plain READ
      issue(1'b1, 16'h0000, 8'd3);
      wait_done(3000);

      // Reset after the 2nd byte, with a start in the same cycle
      acc0 = n_acc;
      issue(1'b0, 16'h0000, 8'd3);
      k = 0;
      while (n_acc < acc0 + 2 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk("two_bytes_before_reset", 32'(n_acc - acc0), 32'd2);
      @(posedge clk);
      #1;
      reset = 1'b1;
      start = 1'b1;
      addr  = 16'h0001;
      len   = 8'd5;
      @(posedge clk);
      #1;
      chk("abort_cs_n", 32'(flash_cs_n), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_sck", 32'(flash_sck), 32'd0);
      reset = 1'b0;
      start = 1'b0;
      exp_q.delete();
      acc0 = n_done;
      bad  = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (data_valid || busy || !flash_cs_n) bad++;
      end
      chk("quiet_after_abort", 32'(bad), 32'd0);
      chk("no_done_after_abort", 32'(n_done - acc0), 32'd0);
      issue(1'b0, 16'h0002, 8'd0);
      wait_done(3000);

      // start while busy is ignored
      ready_mode = 1;
      issue(1'b0, 16'h0100, 8'd4);
      repeat (40) @(posedge clk);
      #1;
      chk("busy_midway", 32'(busy), 32'd1);
      start = 1'b1;
      addr  = 16'h0000;
      len   = 8'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(6000);

      // Randomised requests
      for (int t = 0; t < 10; t++) begin
         issue(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom_range(0, 5)));
         wait_done(6000);
      end

      // Wrap across the top of memory, then a full-length burst
      issue(1'b0, 16'hFFFE, 8'd3);
      wait_done(6000);
      ready_mode = 0;
      issue(1'b0, 16'hFF80, 8'hFF);
      wait_done(40000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/spi_eeprom_reader.md
SPI_EEPROM_READER -- requirements
Module: spi_eeprom_reader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16: EEPROM address width in bits; must be a multiple of 8.
REQ-002 The block SHALL have parameter LEN_W, default 8: width of the burst length field.
REQ-003 The block SHALL have parameter CLK_DIV, default 2: clk cycles per SCK half-period; must be at least 1.
REQ-004 The block SHALL have parameter CS_SETUP, default 2: clk cycles from cs_n falling to the first SCK rising edge, and from the last SCK falling edge to cs_n rising.
REQ-005 Port clk, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
REQ-006 Port reset, input, 1 bit: synchronous reset, active-high.
REQ-007 Port start, input, 1 bit: request pulse; sampled only in IDLE.
REQ-008 Port mode, input, 1 bit: 0 = READ (0x03); 1 = RDSR (0x05).
REQ-009 Port addr, input, ADDR_W bits: start address; captured on start.
REQ-010 Port len, input, LEN_W bits: byte count minus 1; captured on start.
REQ-011 Port busy, output, 1 bit: high from the start-accept cycle until done.
REQ-012 Port data_out, output, 8 bits: received byte.
REQ-013 Port data_valid, output, 1 bit: data_out is valid.
REQ-014 Port data_ready, input, 1 bit: consumer accepts data_out.
REQ-015 Port done, output, 1 bit: one-cycle pulse at transaction end.
REQ-016 Port flash_si, output, 1 bit: MOSI.
REQ-017 Port flash_so, input, 1 bit: MISO.
REQ-018 Port flash_sck, output, 1 bit: SPI clock in mode 0; idles low.
REQ-019 Port flash_cs_n, output, 1 bit: chip select, active-low.
REQ-020 Port flash_wp_n, output, 1 bit: tied to 1.
REQ-021 Port flash_hold_n, output, 1 bit: tied to 1.

Function
REQ-022 The block SHALL implement the state machine IDLE -> CSS -> CMD -> ADDR -> DATA -> CSH -> IDLE; in RDSR mode ADDR SHALL be skipped (CMD -> DATA).
REQ-023 In IDLE, start=1 SHALL capture mode, addr and len, assert busy on the next cycle, and drive cs_n low on the next cycle.
REQ-024 start while busy=1 SHALL be ignored, with no effect on the transaction in progress.
REQ-025 flash_si SHALL change only while SCK is low, MSB first, and SHALL be driven at least CLK_DIV cycles before each SCK rising edge.
REQ-026 flash_so SHALL be sampled in the clk cycle in which SCK rises.
REQ-027 CMD SHALL shift 8 bits, ADDR SHALL shift ADDR_W bits, and flash_si SHALL be 0 during DATA.
REQ-028 DATA SHALL receive (len+1) bytes in READ mode, and exactly 1 byte in RDSR mode with len ignored.
REQ-029 Each byte SHALL load data_out and assert data_valid in the cycle after its 8th sample.
REQ-030 data_valid SHALL stay high, with data_out stable, until data_valid && data_ready.
REQ-031 Backpressure: if the previous byte is still unaccepted when the next byte's first SCK rise is due, SCK SHALL hold low and cs_n SHALL stay low (stall) until acceptance; no bit SHALL be lost or duplicated.
REQ-032 Address increment and wrap across the top of memory SHALL be left to the EEPROM; the block SHALL issue a single address per transaction.
REQ-033 After the last byte is accepted, the block SHALL wait CS_SETUP cycles with SCK low, then raise cs_n; done SHALL pulse in the following cycle with busy low in the same cycle.
REQ-034 When len is all ones, the block SHALL transfer 2^LEN_W bytes, and its internal byte counter SHALL NOT overflow.

Reset
REQ-035 While reset=1, outputs SHALL be: cs_n=1, sck=0, si=0, busy=0, data_valid=0, done=0, data_out=0x00; state SHALL be IDLE.
REQ-036 Reset mid-transaction SHALL abort it in the next cycle, with no done pulse and no further data_valid.
REQ-037 start asserted in the same cycle as reset SHALL be ignored.

Configuration
REQ-038 Macro SPI_EEPROM_RDSR_EN defined: mode=1 SHALL perform RDSR as specified in REQ-022 and REQ-028.
REQ-039 Macro SPI_EEPROM_RDSR_EN undefined: the mode input SHALL be ignored, every transaction SHALL be READ, and the RDSR logic SHALL be absent.

Verification
REQ-040 25AA512 model preloaded 0x0000..0x0003 = DE AD BE EF; READ addr=0x0000 len=3 with data_ready=1 -> bytes DE, AD, BE, EF in order, then one done pulse.
REQ-041 Same preload; data_ready=0 for 20 cycles after the first byte -> SCK stays low, cs_n stays low, data_out holds 0xDE; then AD, BE, EF follow intact.
REQ-042 RDSR with WriteEnable=1 preset in the model (SPI_EEPROM_RDSR_EN defined) -> single byte 0x02, then done.
REQ-043 reset asserted after the 2nd byte of a len=3 READ -> cs_n=1 and busy=0 the next cycle, no done; a new READ addr=0x0002 len=0 -> BE.
REQ-044 start pulsed while busy -> ignored; exactly one done and len+1 bytes for the original request.
REQ-045 CLK_DIV=1 and CLK_DIV=4 builds of the REQ-040 scenario -> identical byte stream; SCK high and low phases measure 1 and 4 clk cycles respectively.
